// File: rtl/booth_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM encodings, step op codes, default width.
// Optional abort input is compiled in with `define BOOTH_ABORT_EN.
package booth_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // Booth recoding of the current multiplier bit pair {Q[0], Q_1}.
    function automatic booth_op_e booth_op(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_ctrl_if.sv
// Request/result bundle of the Booth multiplier; master drives operands, slave returns status and product.
// The abort signal exists only when BOOTH_ABORT_EN is defined.
interface booth_ctrl_if #(
    parameter int WIDTH = booth_ctrl_pkg::DEFAULT_WIDTH
);
    logic                 start;
`ifdef BOOTH_ABORT_EN
    logic                 abort;
`endif
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

`ifdef BOOTH_ABORT_EN
    modport master (output start, output abort, output multiplicand, output multiplier,
                    input busy, input done, input product);
    modport slave  (input start, input abort, input multiplicand, input multiplier,
                    output busy, output done, output product);
`else
    modport master (output start, output multiplicand, output multiplier,
                    input busy, input done, input product);
    modport slave  (input start, input multiplicand, input multiplier,
                    output busy, output done, output product);
`endif

endinterface

// File: rtl/booth_step.sv
// One combinational Booth iteration: add/sub of M selected by {Q[0],Q_1}, then arithmetic
// shift right of the {A,Q,Q_1} cascade. A and M are WIDTH+1 bits so A-M never overflows.
module booth_step
    import booth_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        // NOTE: every path assigns sum, so no latch can be inferred.
        case (booth_op(q_i[0], q1_i))
            OP_ADD:  sum = a_i + m_i;
            OP_SUB:  sum = a_i - m_i;
            default: sum = a_i;
        endcase
    end

    assign a_o  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o  = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o = q_i[0];

endmodule

// File: rtl/booth_ctrl.sv
// Sequencer of the radix-2 Booth multiplier: IDLE/ITER/DONE FSM, step counter and the A/Q/Q_1/M cascade.
// Define BOOTH_ABORT_EN to add an abort input that cancels an iteration without a done pulse.
module booth_ctrl
    import booth_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        CLK,
    input  logic        rst,
    booth_ctrl_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state_q,   state_d;
    logic [WIDTH:0]     a_q,       a_d;
    logic [WIDTH-1:0]   q_q,       q_d;
    logic               q1_q,      q1_d;
    logic [WIDTH-1:0]   m_q,       m_d;
    logic [CW-1:0]      count_q,   count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH:0]     a_step;
    logic [WIDTH-1:0]   q_step;
    logic               q1_step;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .m_i  ({m_q[WIDTH-1], m_q}),
        .a_o  (a_step),
        .q_o  (q_step),
        .q1_o (q1_step)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    m_d     = bus.multiplicand;
                    q_d     = bus.multiplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    count_d = CW'(WIDTH);
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
`ifdef BOOTH_ABORT_EN
                if (bus.abort) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else
`endif
                begin
                    a_d     = a_step;
                    q_d     = q_step;
                    q1_d    = q1_step;
                    count_d = count_q - CW'(1);
                    // Last step: the product is taken from the shifted values, not the old registers.
                    if (count_q == CW'(1)) begin
                        product_d = {a_step[WIDTH-1:0], q_step};
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge state.
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == ST_ITER);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Self-checking bench for booth_ctrl: signed vector table, held-start random stream, async reset abort,
// exhaustive 4-bit sweep, a 6-bit spot check, and the BOOTH_ABORT_EN sequence when that macro is defined.
module tb_booth_ctrl;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    booth_ctrl_if #(.WIDTH(4)) bus4 ();
    booth_ctrl_if #(.WIDTH(6)) bus6 ();

    booth_ctrl #(.WIDTH(4)) dut4 (.CLK(clk), .rst(rst), .bus(bus4));
    booth_ctrl #(.WIDTH(6)) dut6 (.CLK(clk), .rst(rst), .bus(bus6));

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: two's-complement operands of width w, exact product truncated to 2w bits.
    function automatic longint ref_prod(input longint m, input longint q, input int w);
        longint sm, sq, mask;
        sm   = m[w-1] ? m - (longint'(1) << w) : m;
        sq   = q[w-1] ? q - (longint'(1) << w) : q;
        mask = (longint'(1) << (2 * w)) - 1;
        return (sm * sq) & mask;
    endfunction

    // Runs one multiplication on the 4-bit DUT from IDLE and leaves it back in IDLE.
    task automatic do_mult(input logic [3:0] m, input logic [3:0] q, output logic [7:0] prod);
        int n;
        int nbusy;
        bus4.start        = 1'b1;
        bus4.multiplicand = m;
        bus4.multiplier   = q;
        step();
        check("accept_busy", bus4.busy, 1);
        bus4.start        = 1'b0;
        bus4.multiplicand = 4'($urandom);
        bus4.multiplier   = 4'($urandom);
        n     = 0;
        nbusy = 1;
        while (!bus4.done && n < 20) begin
            step();
            n++;
            if (bus4.busy) nbusy++;
        end
        check("latency", n, 4);
        check("busy_cycles", nbusy, 4);
        prod = bus4.product;
        step();
        check("done_one_cycle", bus4.done, 0);
    endtask

    task automatic do_mult6(input logic [5:0] m, input logic [5:0] q, output logic [11:0] prod);
        int n;
        bus6.start        = 1'b1;
        bus6.multiplicand = m;
        bus6.multiplier   = q;
        step();
        bus6.start        = 1'b0;
        bus6.multiplicand = 6'($urandom);
        bus6.multiplier   = 6'($urandom);
        n = 0;
        while (!bus6.done && n < 30) begin
            step();
            n++;
        end
        check("latency6", n, 6);
        prod = bus6.product;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic [7:0]  p;
        logic [11:0] p6;
        logic [3:0]  cm, cq;
        logic        pb;
        int          last_done;
        int          ndone;
        longint      expq[$];

        vecs[0] = '{4'hD, 4'h5, 8'hF1};
        vecs[1] = '{4'h8, 4'h8, 8'h40};
        vecs[2] = '{4'h8, 4'h7, 8'hC8};
        vecs[3] = '{4'h7, 4'hF, 8'hF9};
        vecs[4] = '{4'h0, 4'h0, 8'h00};
        vecs[5] = '{4'h7, 4'h7, 8'h31};
        vecs[6] = '{4'hF, 4'hF, 8'h01};
        vecs[7] = '{4'h8, 4'h1, 8'hF8};

        rst = 1'b1;
        bus4.start = 1'b0; bus4.multiplicand = '0; bus4.multiplier = '0;
        bus6.start = 1'b0; bus6.multiplicand = '0; bus6.multiplier = '0;
`ifdef BOOTH_ABORT_EN
        bus4.abort = 1'b0;
        bus6.abort = 1'b0;
`endif
        repeat (2) step();
        check("rst_busy", bus4.busy, 0);
        check("rst_done", bus4.done, 0);
        check("rst_product", bus4.product, 0);
        check("rst_product6", bus6.product, 0);
        rst = 1'b0;
        step();

        // Basic case and hold through idle cycles.
        do_mult(4'd3, 4'd5, p);
        check("m3_q5", p, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_product", bus4.product, 8'h0F);
            check("hold_no_done", bus4.done, 0);
        end

        // Signed table, back-to-back.
        for (int i = 0; i < 8; i++) begin
            do_mult(vecs[i].m, vecs[i].q, p);
            check($sformatf("vec%0d", i), p, vecs[i].exp);
        end

        // start held high, operands changing each cycle: only accepting-edge operands count.
        last_done = -1;
        for (int i = 0; i < 56; i++) begin
            cm = 4'($urandom);
            cq = 4'($urandom);
            bus4.start        = (i < 48);
            bus4.multiplicand = cm;
            bus4.multiplier   = cq;
            pb = bus4.busy;
            step();
            if (bus4.busy && !pb) expq.push_back(ref_prod(longint'(cm), longint'(cq), 4));
            if (bus4.done) begin
                check("held_pending", expq.size() > 0, 1);
                if (expq.size() > 0) check("held_prod", bus4.product, expq.pop_front());
                if (last_done >= 0) check("done_spacing", i - last_done, 6);
                last_done = i;
            end
        end
        check("held_drained", expq.size(), 0);
        check("held_results_seen", last_done > 40, 1);

        // Asynchronous reset during the second ITER step.
        do_mult(4'd3, 4'd5, p);
        bus4.start = 1'b1; bus4.multiplicand = 4'd5; bus4.multiplier = 4'd3;
        step();
        bus4.start = 1'b0;
        step();
        step();
        check("pre_rst_busy", bus4.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", bus4.busy, 0);
        check("async_rst_done", bus4.done, 0);
        check("async_rst_product", bus4.product, 0);
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus4.done) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        do_mult(4'd2, 4'd3, p);
        check("post_rst_m2_q3", p, 8'h06);

        // Exhaustive 4-bit sweep.
        for (int m = 0; m < 16; m++) begin
            for (int q = 0; q < 16; q++) begin
                do_mult(4'(m), 4'(q), p);
                check($sformatf("sweep_%0d_%0d", m, q), p, ref_prod(longint'(m), longint'(q), 4));
            end
        end

        // 6-bit instance.
        do_mult6(6'h20, 6'h20, p6);
        check("w6_min_min", p6, 12'h400);
        for (int i = 0; i < 6; i++) begin
            cm = 4'($urandom);
            cq = 4'($urandom);
            begin
                logic [5:0] m6, q6;
                m6 = 6'($urandom);
                q6 = 6'($urandom);
                do_mult6(m6, q6, p6);
                check("w6_random", p6, ref_prod(longint'(m6), longint'(q6), 6));
            end
        end

`ifdef BOOTH_ABORT_EN
        do_mult(4'd3, 4'd3, p);
        check("abort_pre_m3_q3", p, 8'h09);
        bus4.start = 1'b1; bus4.multiplicand = 4'd2; bus4.multiplier = 4'd2;
        step();
        bus4.start = 1'b0;
        step();
        bus4.abort = 1'b1;
        step();
        bus4.abort = 1'b0;
        check("abort_busy", bus4.busy, 0);
        check("abort_done", bus4.done, 0);
        check("abort_product", bus4.product, 8'h09);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus4.done || bus4.busy) ndone++;
        end
        check("abort_stays_idle", ndone, 0);
        check("abort_product_kept", bus4.product, 8'h09);
        bus4.start = 1'b1; bus4.abort = 1'b1; bus4.multiplicand = 4'd2; bus4.multiplier = 4'd2;
        step();
        bus4.start = 1'b0; bus4.abort = 1'b0;
        check("start_beats_abort", bus4.busy, 1);
        ndone = 0;
        while (!bus4.done && ndone < 20) begin
            step();
            ndone++;
        end
        check("abort_after_m2_q2", bus4.product, 8'h04);
        step();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
